// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity mode codes and a
// parameter legality check used by the TX and RX blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic bit uart_params_legal(input int dbit, input int oversample,
                                           input int stop_bits, input int parity);
    return (dbit >= 5) && (dbit <= 9) &&
           (oversample >= 4) && (oversample <= 32) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (parity >= PARITY_NONE) && (parity <= PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-deep holding register so that
// frames can be sent back-to-back without an idle gap on the line.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic            CLOCK_TX,
  input  logic            RESET,
  input  logic            s_tick,
  input  logic            SEND,
  input  logic [DBIT-1:0] TX_DATA,
  output logic            TX_READY,
  output logic            NINTO,
  output logic            TX_DONE,
  output logic            SO
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (!uart_params_legal(DBIT, OVERSAMPLE, STOP_BITS, PARITY)) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter combination");
  end

  function automatic logic frame_parity(input logic [DBIT-1:0] w);
    return (PARITY == PARITY_EVEN) ? ^w : ~^w;
  endfunction

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            par_q, par_d;
  logic            so_q, so_d;
  logic            ninto_q, ninto_d;
  logic            done_q, done_d;

  logic            accept;
  logic            bit_end;
  logic [TW-1:0]   tick_adv;
  logic            start_frame;
  logic [DBIT-1:0] start_word;
  logic            hold_wr;

  assign accept   = SEND && !hold_full_q;
  assign bit_end  = s_tick && (tick_q == TICK_LAST);
  assign tick_adv = bit_end ? '0 : (s_tick ? tick_q + TW'(1) : tick_q);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    done_d      = 1'b0;
    start_frame = 1'b0;
    start_word  = TX_DATA;
    hold_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // s_tick is deliberately ignored here; the counter restarts on load
        start_frame = accept;
      end
      ST_START: begin
        tick_d  = tick_adv;
        hold_wr = accept;
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        tick_d  = tick_adv;
        hold_wr = accept;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_PAR: begin
        tick_d  = tick_adv;
        hold_wr = accept;
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        tick_d = tick_adv;
        if (bit_end && (stop_q == STOP_LAST)) begin
          done_d = 1'b0 | 1'b1;
          if (hold_full_q) begin
            start_frame = 1'b1;
            start_word  = hold_q;
            hold_d      = '0;
            hold_full_d = 1'b0;
          end else if (accept) begin
            // Bypass: the word goes straight to the shifter, never via hold
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_wr = accept;
          if (bit_end) begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tick_d      = '0;
        bit_d       = '0;
        stop_d      = 1'b0;
        shift_d     = '0;
        hold_d      = '0;
        hold_full_d = 1'b0;
        par_d       = 1'b0;
      end
    endcase

    if (start_frame) begin
      state_d = ST_START;
      tick_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      shift_d = start_word;
      par_d   = frame_parity(start_word);
    end

    if (hold_wr) begin
      hold_d      = TX_DATA;
      hold_full_d = 1'b1;
    end

    // The line level is derived from the next state so SO is a pure flop
    case (state_d)
      ST_START: so_d = 1'b0;
      ST_DATA:  so_d = shift_d[0];
      ST_PAR:   so_d = par_d;
      default:  so_d = 1'b1;
    endcase
    ninto_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_TX) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      so_q        <= 1'b1;
      ninto_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      so_q        <= so_d;
      ninto_q     <= ninto_d;
      done_q      <= done_d;
    end
  end

  assign TX_READY = ~hold_full_q;
  assign NINTO    = ninto_q;
  assign TX_DONE  = done_q;
  assign SO       = so_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomised bench for uart_tx_cfg: three configurations are driven side by
// side and compared every cycle against a frame-level bit-list model.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int ND = 3;
  localparam int P_DBIT [ND] = '{8, 7, 5};
  localparam int P_OS   [ND] = '{16, 8, 4};
  localparam int P_STOP [ND] = '{1, 2, 1};
  localparam int P_PAR  [ND] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD};
  localparam int N_CYCLES = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          s_tick;
  logic [ND-1:0] send;
  logic [7:0]    din0;
  logic [6:0]    din1;
  logic [4:0]    din2;
  logic [ND-1:0] rdy_o, busy_o, done_o, so_o;

  uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY(PARITY_NONE)) u_dut0 (
    .CLOCK_TX(clk), .RESET(rst), .s_tick(s_tick), .SEND(send[0]), .TX_DATA(din0),
    .TX_READY(rdy_o[0]), .NINTO(busy_o[0]), .TX_DONE(done_o[0]), .SO(so_o[0]));
  uart_tx_cfg #(.DBIT(7), .OVERSAMPLE(8), .STOP_BITS(2), .PARITY(PARITY_EVEN)) u_dut1 (
    .CLOCK_TX(clk), .RESET(rst), .s_tick(s_tick), .SEND(send[1]), .TX_DATA(din1),
    .TX_READY(rdy_o[1]), .NINTO(busy_o[1]), .TX_DONE(done_o[1]), .SO(so_o[1]));
  uart_tx_cfg #(.DBIT(5), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY(PARITY_ODD)) u_dut2 (
    .CLOCK_TX(clk), .RESET(rst), .s_tick(s_tick), .SEND(send[2]), .TX_DATA(din2),
    .TX_READY(rdy_o[2]), .NINTO(busy_o[2]), .TX_DONE(done_o[2]), .SO(so_o[2]));

  // Model: the current frame is a list of line levels, each OVERSAMPLE ticks long
  logic [15:0] m_bits [ND];
  int          m_len  [ND];
  int          m_pos  [ND];
  int          m_left [ND];
  int          m_word [ND];
  int          m_hold [ND];
  bit          m_busy [ND];
  bit          m_hold_v [ND];
  bit          m_done [ND];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic start_frame(input int d, input int w);
    logic [15:0] b;
    int n;
    int ones;
    b = '1;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < P_DBIT[d]; i++) begin
      b[n] = w[i];
      n++;
    end
    ones = $countones(w);
    if (P_PAR[d] == PARITY_EVEN) begin
      b[n] = (ones % 2 == 1);
      n++;
    end else if (P_PAR[d] == PARITY_ODD) begin
      b[n] = (ones % 2 == 0);
      n++;
    end
    for (int s = 0; s < P_STOP[d]; s++) begin
      b[n] = 1'b1;
      n++;
    end
    m_bits[d] = b;
    m_len[d]  = n;
    m_pos[d]  = 0;
    m_left[d] = P_OS[d];
    m_word[d] = w;
    m_busy[d] = 1'b1;
  endtask

  task automatic model_step(input int d, input bit r, input bit tk, input bit snd, input int w);
    bit acc;
    bit ended;
    m_done[d] = 1'b0;
    if (r) begin
      m_busy[d]   = 1'b0;
      m_hold_v[d] = 1'b0;
      return;
    end
    acc = snd && !m_hold_v[d];
    if (!m_busy[d]) begin
      if (acc) start_frame(d, w);
    end else begin
      ended = 1'b0;
      if (tk) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_pos[d]++;
          m_left[d] = P_OS[d];
          ended = (m_pos[d] == m_len[d]);
        end
      end
      if (ended) begin
        m_done[d] = 1'b1;
        $display("dut%0d frame sent data=0x%0h", d, m_word[d]);
        if (m_hold_v[d]) begin
          m_hold_v[d] = 1'b0;
          start_frame(d, m_hold[d]);
        end else if (acc) begin
          start_frame(d, w);
        end else begin
          m_busy[d] = 1'b0;
        end
      end else if (acc) begin
        m_hold_v[d] = 1'b1;
        m_hold[d]   = w;
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    s_tick = 1'b0;
    send   = '0;
    din0   = '0;
    din1   = '0;
    din2   = '0;
    for (int d = 0; d < ND; d++) begin
      m_busy[d]   = 1'b0;
      m_hold_v[d] = 1'b0;
      m_done[d]   = 1'b0;
    end

    for (int cyc = 0; cyc < N_CYCLES && (n_checks - n_pass) < 50; cyc++) begin
      bit          r;
      bit          tk;
      bit          end_next;
      bit [ND-1:0] sn;
      int          w [ND];
      logic        exp_so;

      @(negedge clk);
      r  = (cyc < 3) || ($urandom_range(2999) == 0);
      tk = (cyc < N_CYCLES / 2) ? (cyc % 4 == 3) : ($urandom_range(2) == 0);
      for (int d = 0; d < ND; d++) begin
        w[d] = int'($urandom) & ((1 << P_DBIT[d]) - 1);
        // Bias a SEND onto the exact stop-end edge to exercise the bypass path
        end_next = m_busy[d] && !m_hold_v[d] && tk && (m_left[d] == 1) &&
                   (m_pos[d] == m_len[d] - 1);
        if (end_next)
          sn[d] = ($urandom_range(1) == 0);
        else if (!m_busy[d])
          sn[d] = ($urandom_range(9) == 0);
        else
          sn[d] = ($urandom_range(39) == 0);
      end
      rst    = r;
      s_tick = tk;
      send   = sn;
      din0   = 8'(w[0]);
      din1   = 7'(w[1]);
      din2   = 5'(w[2]);

      @(posedge clk);
      for (int d = 0; d < ND; d++)
        model_step(d, r, tk, sn[d], w[d]);

      #1;
      for (int d = 0; d < ND; d++) begin
        exp_so = m_busy[d] ? m_bits[d][m_pos[d]] : 1'b1;
        check_eq($sformatf("d%0d SO", d),       16'(so_o[d]),   16'(exp_so));
        check_eq($sformatf("d%0d NINTO", d),    16'(busy_o[d]), 16'(m_busy[d]));
        check_eq($sformatf("d%0d TX_READY", d), 16'(rdy_o[d]),  16'(!m_hold_v[d]));
        check_eq($sformatf("d%0d TX_DONE", d),  16'(done_o[d]), 16'(m_done[d]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
